// File: rtl/mem_readback_pkg.sv
// Shared types for the block-RAM readback streamer.
package mem_readback_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int CSUM_W = 32;

endpackage

// File: rtl/mem_readback_skid_buf.sv
// Two-entry FIFO (data + last flag) whose head entry drives the output stream directly.
module mem_readback_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         din_last,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         dout_last,
  output logic         dout_valid,
  output logic [1:0]   count
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic IDX = 1'(gi);
    logic [W-1:0] data_q;
    logic         last_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        data_q <= '0;
        last_q <= 1'b0;
      end else if (push && (wr_ptr_q == IDX)) begin
        data_q <= din;
        last_q <= din_last;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry is a plain register, so data/last cannot move while stalled.
  assign dout       = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
  assign dout_last  = rd_ptr_q ? g_entry[1].last_q : g_entry[0].last_q;
  assign dout_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/mem_readback_streamer.sv
// Sweeps an address window over a block-RAM read port and streams the words out with a last marker.
// Optional running checksum of accepted words is built only when CHECKSUM_EN is defined.
module mem_readback_streamer
  import mem_readback_pkg::*;
#(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 2048
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(DEPTH_MEM)-1:0] start_addr,
  input  logic [$clog2(DEPTH_MEM):0]   num_words,
  output logic [31:0]                  mem_raddr,
  input  logic [WID_MEM-1:0]           mem_dout,
  output logic [WID_MEM-1:0]           m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic [CSUM_W-1:0]            checksum
);

  localparam int AW = $clog2(DEPTH_MEM);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH_MEM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;

  logic          pop;
  logic          issue;
  logic          credit_ok;
  logic [1:0]    occ;
  logic [AW:0]   words_clamped;

  mem_readback_skid_buf #(.W(WID_MEM)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q),
    .din        (mem_dout),
    .din_last   (inflight_last_q),
    .pop        (pop),
    .dout       (m_data),
    .dout_last  (m_last),
    .dout_valid (m_valid),
    .count      (occ)
  );

  // raddr_q holds the next address to read; an issue is the edge at which the
  // memory samples it, so the word lands on mem_dout and is pushed one edge later.
  always_comb begin
    pop           = m_valid & m_ready;
    credit_ok     = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    issue         = (state_q == RUN) && (remaining_q != '0) && credit_ok;
    words_clamped = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  end

  always_comb begin
    state_d         = state_q;
    raddr_d         = raddr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == (AW+1)'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          raddr_d     = start_addr;
          remaining_d = words_clamped;
          state_d     = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          remaining_d = remaining_q - (AW+1)'(1);
          if (remaining_q == (AW+1)'(1)) begin
            state_d = DRAIN;
          end else begin
            raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (occ == {1'b0, pop})) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      raddr_q         <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign mem_raddr = {{(32-AW){1'b0}}, raddr_q};
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q + CSUM_W'(m_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Directed bench for mem_readback_streamer against a preloaded ram[i] = i memory model.
module tb_mem_readback_streamer;

  localparam int WID   = 16;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     num_words;
  logic [31:0]     mem_raddr;
  logic [WID-1:0]  mem_dout;
  logic [WID-1:0]  m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic            busy;
  logic            done;
  logic [31:0]     checksum;

  logic [WID-1:0]  ram [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= ram[mem_raddr[AW-1:0]];

  mem_readback_streamer #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
    .mem_raddr  (mem_raddr),
    .mem_dout   (mem_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int got, first_valid, last_acc, done_cnt, done_cyc, busy_cnt;
  logic [31:0] csum_done, csum_c0;
  int raddrs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sweep; observation points are 1 time unit after each clock edge,
  // cycle 0 being the one right after the edge that samples start.
  task automatic run_sweep(input int sa, input int n, input bit rnd, input bit disturb, input string tag);
    int nexp, budget, cyc;
    bit fin, stalled;
    logic [WID-1:0] held_data;
    logic held_last;
    nexp = (n > DEPTH) ? DEPTH : n;
    budget = 8 * nexp + 20;
    got = 0; first_valid = -1; last_acc = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    raddrs.delete();
    stalled = 0; fin = 0; cyc = 0;
    held_data = '0; held_last = 1'b0;
    start_addr = AW'(sa);
    num_words  = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < budget) begin
      if (disturb && cyc == 1) begin
        start = 1'b1; start_addr = 11'd999; num_words = 12'd5;
      end else begin
        start = 1'b0;
      end
      if (cyc == 0) begin
        raddrs.push_back(int'(mem_raddr));
        csum_c0 = checksum;
      end else if (int'(mem_raddr) != raddrs[$]) begin
        raddrs.push_back(int'(mem_raddr));
      end
      if (busy) busy_cnt++;
      if (stalled) begin
        chk({tag, " stall_valid"}, 32'(m_valid), 32'd1);
        chk({tag, " stall_data"}, 32'(m_data), 32'(held_data));
        chk({tag, " stall_last"}, 32'(m_last), 32'(held_last));
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        chk({tag, " data"}, 32'(m_data), 32'((sa + got) % DEPTH));
        chk({tag, " last"}, 32'(m_last), (got == nexp - 1) ? 32'd1 : 32'd0);
        got++;
        last_acc = cyc;
        stalled = 0;
      end else if (m_valid) begin
        stalled = 1;
        held_data = m_data;
        held_last = m_last;
      end else begin
        stalled = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        csum_done = checksum;
      end else if (done_cnt > 0) begin
        chk({tag, " busy_after_done"}, 32'(busy), 32'd0);
        fin = 1;
      end
      if (!fin) begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    m_ready = 1'b0;
    chk({tag, " finished_in_budget"}, 32'(fin), 32'd1);
    chk({tag, " word_count"}, 32'(got), 32'(nexp));
    chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    if (nexp > 0) chk({tag, " done_after_last"}, 32'(done_cyc), 32'(last_acc + 1));
    tick();
  endtask

  initial begin
    int exp_ra [4];
    bit found;
    exp_ra = '{2046, 2047, 0, 1};
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
    reset = 1'b0; start = 1'b0; m_ready = 1'b0; start_addr = '0; num_words = '0;
    repeat (3) tick();

    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst m_last", 32'(m_last), 32'd0);
    chk("rst m_data", 32'(m_data), 32'd0);
    chk("rst mem_raddr", mem_raddr, 32'd0);
    chk("rst checksum", checksum, 32'd0);
    reset = 1'b1;
    tick();

    run_sweep(0, 8, 1'b0, 1'b0, "t1");
    chk("t1 first_valid", 32'(first_valid), 32'd2);
    chk("t1 last_accept", 32'(last_acc), 32'd9);
    chk("t1 done_cyc", 32'(done_cyc), 32'd10);
    chk("t1 busy_cycles", 32'(busy_cnt), 32'd11);

    run_sweep(100, 16, 1'b1, 1'b1, "t2");

    run_sweep(2046, 4, 1'b0, 1'b0, "t3");
    chk("t3 raddr_count", 32'(raddrs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t3 raddr", (raddrs.size() > i) ? 32'(raddrs[i]) : 32'hFFFF_FFFF, 32'(exp_ra[i]));

    run_sweep(7, 0, 1'b0, 1'b0, "t4");
    chk("t4 first_valid", 32'(first_valid), 32'hFFFF_FFFF);
    chk("t4 done_cyc", 32'(done_cyc), 32'd0);
    chk("t4 busy_cycles", 32'(busy_cnt), 32'd1);

    run_sweep(5, 3000, 1'b0, 1'b0, "clamp");

    start_addr = 11'd300; num_words = 12'd16; start = 1'b1;
    tick();
    start = 1'b0; m_ready = 1'b1; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_valid && m_data == 16'd305) found = 1;
      else tick();
    end
    chk("t5 reached_word5", 32'(found), 32'd1);
    reset = 1'b0;
    tick();
    chk("t5 m_valid", 32'(m_valid), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 mem_raddr", mem_raddr, 32'd0);
    chk("t5 done", 32'(done), 32'd0);
    reset = 1'b1; m_ready = 1'b0;
    tick();
    run_sweep(300, 16, 1'b0, 1'b0, "t5b");

    run_sweep(0, 8, 1'b0, 1'b0, "t6a");
`ifdef CHECKSUM_EN
    chk("t6a checksum", csum_done, 32'd28);
`else
    chk("t6a checksum", csum_done, 32'd0);
`endif
    run_sweep(0, 4, 1'b1, 1'b0, "t6b");
    chk("t6b checksum_cleared", csum_c0, 32'd0);
`ifdef CHECKSUM_EN
    chk("t6b checksum", csum_done, 32'd6);
`else
    chk("t6b checksum", csum_done, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
